// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared widths, counter helpers and FSM encoding for touch zone debounce
package touch_pkg;

  localparam int X_W_DEF = 10;
  localparam int Y_W_DEF = 9;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_PRESSED = 2'd2
  } state_t;

  // Hold counter stops at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/touch_zone_match.sv
// rtl/touch_zone_match.sv - combinational zone comparator array with lowest-index priority
module touch_zone_match
  import touch_pkg::*;
#(
  parameter int N_ZONES = 4,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int IDX_W   = 2
) (
  input  logic [X_W-1:0]         i_tor_x,
  input  logic [Y_W-1:0]         i_tor_y,
  input  logic [N_ZONES*X_W-1:0] i_zone_x1,
  input  logic [N_ZONES*X_W-1:0] i_zone_x2,
  input  logic [N_ZONES*Y_W-1:0] i_zone_y1,
  input  logic [N_ZONES*Y_W-1:0] i_zone_y2,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_idx
);

  logic [N_ZONES-1:0] w_hits;

  // An inverted rectangle (x1>x2 or y1>y2) can never satisfy both bounds, so it disables itself.
  genvar g;
  generate
    for (g = 0; g < N_ZONES; g++) begin : g_zone
      logic [X_W-1:0] w_x1, w_x2;
      logic [Y_W-1:0] w_y1, w_y2;
      assign w_x1 = i_zone_x1[g*X_W +: X_W];
      assign w_x2 = i_zone_x2[g*X_W +: X_W];
      assign w_y1 = i_zone_y1[g*Y_W +: Y_W];
      assign w_y2 = i_zone_y2[g*Y_W +: Y_W];
      assign w_hits[g] = (i_tor_x >= w_x1) && (i_tor_x <= w_x2) &&
                         (i_tor_y >= w_y1) && (i_tor_y <= w_y2);
    end
  endgenerate

  // Scan downward so the lowest matching index is written last and wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/touch_zone_debounce.sv
// rtl/touch_zone_debounce.sv - debounced press/release/auto-repeat detection over rectangular touch zones
module touch_zone_debounce
  import touch_pkg::*;
#(
  parameter int         N_ZONES      = 4,
  parameter int         X_W          = X_W_DEF,
  parameter int         Y_W          = Y_W_DEF,
  parameter logic [1:0] SAMPLE_PHASE = 2'd1,
  parameter int         DEBOUNCE_N   = 3,
  parameter int         RELEASE_N    = 2,
  parameter int         HOLD_N       = 20,
  parameter int         REPEAT_N     = 5,
  parameter int         REPEAT_EN    = 1,
  parameter int         IDX_W        = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             clcount,
  input  logic [X_W-1:0]         tor_x,
  input  logic [Y_W-1:0]         tor_y,
  input  logic [N_ZONES*X_W-1:0] zone_x1,
  input  logic [N_ZONES*X_W-1:0] zone_x2,
  input  logic [N_ZONES*Y_W-1:0] zone_y1,
  input  logic [N_ZONES*Y_W-1:0] zone_y2,
  output logic                   outtd,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   repeat_pulse,
  output logic [IDX_W-1:0]       zone_idx
);

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_N);
  localparam logic [CNT_W-1:0] REL_C = CNT_W'(RELEASE_N);
  localparam logic [CNT_W-1:0] HLD_C = CNT_W'(HOLD_N);
  localparam logic [CNT_W-1:0] RPT_C = CNT_W'(REPEAT_N);

  state_t             r_state, w_state;
  logic [IDX_W-1:0]   r_cand, w_cand;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [CNT_W-1:0]   r_miss, w_miss;
  logic [CNT_W-1:0]   r_hold, w_hold;
  logic [CNT_W-1:0]   r_rpt, w_rpt;
  logic               r_outtd, w_outtd;
  logic [IDX_W-1:0]   r_zone_idx, w_zone_idx;
  logic               r_press, w_press;
  logic               r_release, w_release;
  logic               r_repeat, w_repeat;

  logic               w_sample;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_miss_inc;
  logic [CNT_W-1:0]   w_hold_inc;
  logic [CNT_W-1:0]   w_rpt_inc;

  touch_zone_match #(
    .N_ZONES (N_ZONES),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .IDX_W   (IDX_W)
  ) u_match (
    .i_tor_x   (tor_x),
    .i_tor_y   (tor_y),
    .i_zone_x1 (zone_x1),
    .i_zone_x2 (zone_x2),
    .i_zone_y1 (zone_y1),
    .i_zone_y2 (zone_y2),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

  assign w_sample   = enable && (clcount == SAMPLE_PHASE);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;
  assign w_hold_inc = sat_inc(r_hold);
  assign w_rpt_inc  = r_rpt + 1'b1;

  always_comb begin
    w_state    = r_state;
    w_cand     = r_cand;
    w_cnt      = r_cnt;
    w_miss     = r_miss;
    w_hold     = r_hold;
    w_rpt      = r_rpt;
    w_outtd    = r_outtd;
    w_zone_idx = r_zone_idx;
    w_press    = 1'b0;
    w_release  = 1'b0;
    w_repeat   = 1'b0;
    if (w_sample) begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            w_cand = w_idx;
            w_cnt  = 8'd1;
            if (DEBOUNCE_N == 1) begin
              w_state    = ST_PRESSED;
              w_press    = 1'b1;
              w_outtd    = 1'b1;
              w_zone_idx = w_idx;
              w_cnt      = '0;
              w_miss     = '0;
              w_hold     = '0;
              w_rpt      = '0;
            end else begin
              w_state = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (!w_hit) begin
            w_state = ST_IDLE;
            w_cnt   = '0;
          end else if (w_idx == r_cand) begin
            if (w_cnt_inc == DEB_C) begin
              w_state    = ST_PRESSED;
              w_press    = 1'b1;
              w_outtd    = 1'b1;
              w_zone_idx = r_cand;
              w_cnt      = '0;
              w_miss     = '0;
              w_hold     = '0;
              w_rpt      = '0;
            end else begin
              w_cnt = w_cnt_inc;
            end
          end else begin
            w_cand = w_idx;
            w_cnt  = 8'd1;
          end
        end
        ST_PRESSED: begin
          if (w_hit && (w_idx == r_zone_idx)) begin
            w_miss = '0;
            w_hold = w_hold_inc;
            // First repeat keys off hold_cnt; later ones off a separate period counter,
            // so repeats keep coming after hold_cnt saturates.
            if (r_hold < HLD_C) begin
              if (w_hold_inc == HLD_C) begin
                w_repeat = (REPEAT_EN != 0);
                w_rpt    = '0;
              end
            end else if (w_rpt_inc == RPT_C) begin
              w_repeat = (REPEAT_EN != 0);
              w_rpt    = '0;
            end else begin
              w_rpt = w_rpt_inc;
            end
          end else if (w_miss_inc == REL_C) begin
            w_state   = ST_IDLE;
            w_release = 1'b1;
            w_outtd   = 1'b0;
            w_miss    = '0;
          end else begin
            w_miss = w_miss_inc;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_outtd = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_miss     <= '0;
      r_hold     <= '0;
      r_rpt      <= '0;
      r_outtd    <= 1'b0;
      r_zone_idx <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cand     <= w_cand;
      r_cnt      <= w_cnt;
      r_miss     <= w_miss;
      r_hold     <= w_hold;
      r_rpt      <= w_rpt;
      r_outtd    <= w_outtd;
      r_zone_idx <= w_zone_idx;
      r_press    <= w_press;
      r_release  <= w_release;
      r_repeat   <= w_repeat;
    end
  end

  assign outtd         = r_outtd;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;
  assign zone_idx      = r_zone_idx;

endmodule

// File: tb/tb_touch_zone_debounce.sv
// tb/tb_touch_zone_debounce.sv - self-checking bench for touch_zone_debounce
module tb_touch_zone_debounce;

  localparam int NZ  = 4;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int DEB = 3;
  localparam int REL = 2;
  localparam int HLD = 20;
  localparam int RPT = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        clcount = 2'd0;
  logic [XW-1:0]     tor_x = '0;
  logic [YW-1:0]     tor_y = '0;
  logic [NZ*XW-1:0]  zx1 = '0, zx2 = '0;
  logic [NZ*YW-1:0]  zy1 = '0, zy2 = '0;

  logic       a_outtd, a_press, a_rel, a_rep;
  logic [1:0] a_idx;
  logic       b_outtd, b_press, b_rel, b_rep;
  logic [1:0] b_idx;

  touch_zone_debounce u_dut (
    .clk(clk), .reset(reset), .enable(enable), .clcount(clcount),
    .tor_x(tor_x), .tor_y(tor_y),
    .zone_x1(zx1), .zone_x2(zx2), .zone_y1(zy1), .zone_y2(zy2),
    .outtd(a_outtd), .press_pulse(a_press), .release_pulse(a_rel),
    .repeat_pulse(a_rep), .zone_idx(a_idx)
  );

  touch_zone_debounce #(.REPEAT_EN(0)) u_norep (
    .clk(clk), .reset(reset), .enable(enable), .clcount(clcount),
    .tor_x(tor_x), .tor_y(tor_y),
    .zone_x1(zx1), .zone_x2(zx2), .zone_y1(zy1), .zone_y2(zy2),
    .outtd(b_outtd), .press_pulse(b_press), .release_pulse(b_rel),
    .repeat_pulse(b_rep), .zone_idx(b_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int mx1[NZ], mx2[NZ], my1[NZ], my2[NZ];

  task automatic set_zone(input int i, input int x1, input int x2, input int y1, input int y2);
    zx1[i*XW +: XW] = XW'(x1);
    zx2[i*XW +: XW] = XW'(x2);
    zy1[i*YW +: YW] = YW'(y1);
    zy2[i*YW +: YW] = YW'(y2);
    mx1[i] = x1; mx2[i] = x2; my1[i] = y1; my2[i] = y2;
  endtask

  function automatic int zone_hit(input int x, input int y);
    for (int i = 0; i < NZ; i++)
      if (mx1[i] <= x && x <= mx2[i] && my1[i] <= y && y <= my2[i]) return i;
    return -1;
  endfunction

  // Reference model: tracks a run of identical-zone samples, a run of misses,
  // and the count of held samples since the press.
  bit m_pressed;
  int m_pz, streak_z, streak_n, miss_n, held;
  bit e_press, e_rel, e_rep;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pressed = 0; m_pz = 0; streak_z = -1; streak_n = 0; miss_n = 0; held = 0;
      e_press = 0; e_rel = 0; e_rep = 0;
    end else begin
      int h;
      e_press = 0; e_rel = 0; e_rep = 0;
      if (enable && clcount == 2'd1) begin
        h = zone_hit(int'(tor_x), int'(tor_y));
        if (!m_pressed) begin
          if (h < 0) begin
            streak_z = -1; streak_n = 0;
          end else if (h == streak_z) begin
            streak_n++;
          end else begin
            streak_z = h; streak_n = 1;
          end
          if (streak_n >= DEB) begin
            m_pressed = 1; m_pz = h; e_press = 1; held = 0; miss_n = 0;
            streak_z = -1; streak_n = 0;
          end
        end else if (h == m_pz) begin
          miss_n = 0;
          held++;
          if (held == HLD || (held > HLD && (held - HLD) % RPT == 0)) e_rep = 1;
        end else begin
          miss_n++;
          if (miss_n >= REL) begin
            m_pressed = 0; e_rel = 1; miss_n = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("outtd", a_outtd, m_pressed);
      chk("press", a_press, e_press);
      chk("release", a_rel, e_rel);
      chk("repeat", a_rep, e_rep);
      chk("zone_idx", a_idx, m_pz);
      chk("norep_outtd", b_outtd, m_pressed);
      chk("norep_press", b_press, e_press);
      chk("norep_release", b_rel, e_rel);
      chk("norep_repeat", b_rep, 1'b0);
      chk("norep_zone_idx", b_idx, m_pz);
    end
  end

  task automatic drive(input bit en, input logic [1:0] cc, input int x, input int y);
    enable = en; clcount = cc; tor_x = XW'(x); tor_y = YW'(y);
    @(posedge clk);
    #2;
  endtask

  task automatic sample(input int x, input int y);
    drive(1'b1, 2'd1, x, y);
  endtask

  int reps_a, reps_b, first_rep, second_rep;
  logic [1:0] cc;

  initial begin
    set_zone(0, 344, 486, 121, 220);
    set_zone(1, 380, 450, 100, 200);
    set_zone(2, 500, 600, 300, 400);
    set_zone(3, 700, 650, 10, 20);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outtd", a_outtd, 1'b0);
    chk("rst_idx", a_idx, 2'd0);
    chk("rst_press", a_press, 1'b0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 0, 0);

    // Basic press on zone 0
    sample(400, 150);
    chk("p1_press", a_press, 1'b0);
    sample(400, 150);
    chk("p2_press", a_press, 1'b0);
    sample(400, 150);
    chk("p3_press", a_press, 1'b1);
    chk("p3_idx", a_idx, 2'd0);
    chk("p3_outtd", a_outtd, 1'b1);
    drive(1'b1, 2'd0, 400, 150);
    chk("press_one_clk", a_press, 1'b0);

    // Single miss does not release; two consecutive misses do
    sample(0, 0);
    chk("miss1_outtd", a_outtd, 1'b1);
    sample(400, 150);
    chk("miss_hit_rel", a_rel, 1'b0);
    sample(0, 0);
    sample(0, 0);
    chk("rel_pulse", a_rel, 1'b1);
    chk("rel_outtd", a_outtd, 1'b0);
    chk("rel_idx_kept", a_idx, 2'd0);

    // Alternating zone1/zone2 never presses
    for (int i = 0; i < 10; i++) sample((i % 2) ? 550 : 420, (i % 2) ? 350 : 110);
    chk("alt_outtd", a_outtd, 1'b0);
    repeat (3) sample(400, 150);
    chk("overlap_idx", a_idx, 2'd0);
    sample(0, 0);
    sample(0, 0);
    chk("rel2", a_rel, 1'b1);
    repeat (3) sample(550, 350);
    chk("rearm_idx", a_idx, 2'd2);
    sample(0, 0);
    sample(0, 0);

    // Hold zone 0 for 30 samples
    reps_a = 0; reps_b = 0; first_rep = 0; second_rep = 0;
    for (int k = 1; k <= 30; k++) begin
      sample(400, 150);
      if (a_rep) begin
        reps_a++;
        if (first_rep == 0) first_rep = k; else if (second_rep == 0) second_rep = k;
      end
      if (b_rep) reps_b++;
    end
    chk("rep_count", reps_a, 2);
    chk("rep_first", first_rep, 23);
    chk("rep_second", second_rep, 28);
    chk("norep_count", reps_b, 0);

    // Non-sample cycles leave the press untouched
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 1) == 0) drive(1'b0, 2'($urandom_range(0, 3)), 550, 350);
      else begin
        cc = 2'($urandom_range(0, 2));
        if (cc >= 2'd1) cc = cc + 2'd1;
        drive(1'b1, cc, 550, 350);
      end
    end
    chk("hold_outtd", a_outtd, 1'b1);
    chk("hold_idx", a_idx, 2'd0);

    // Reset mid-press: immediate clear, no release strobe
    reset = 1'b0;
    #1;
    chk("rst_mid_outtd", a_outtd, 1'b0);
    chk("rst_mid_rel", a_rel, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_mid_rel2", a_rel, 1'b0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int x, y, z;
      x = int'(tor_x); y = int'(tor_y);
      if ($urandom_range(0, 99) < 2) begin
        z = $urandom_range(0, NZ - 1);
        x = $urandom_range(0, 900); y = $urandom_range(0, 450);
        if ($urandom_range(0, 9) < 8)
          set_zone(z, x, x + $urandom_range(0, 120), y, y + $urandom_range(0, 60));
        else
          set_zone(z, x + 50, x, y, y + 10);
      end
      if ($urandom_range(0, 99) < 25) begin
        z = $urandom_range(0, NZ - 1);
        if ($urandom_range(0, 3) != 0 && mx1[z] <= mx2[z] && my1[z] <= my2[z]) begin
          x = $urandom_range(mx1[z], mx2[z]);
          y = $urandom_range(my1[z], my2[z]);
        end else begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(0, 511);
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
      end
      drive($urandom_range(0, 9) != 0,
            ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3)), x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
